// File: rtl/fifo_burst_reader_if.sv
// FIFO read-port and downstream stream signals of the burst reader, bundled as one port.
// The master modport is the reader; the slave modport is the FIFO plus the downstream sink.
interface fifo_burst_reader_if #(
    parameter int WIDTH = 8,
    parameter int PTR   = 4
);
    logic             fifo_rden;
    logic [WIDTH-1:0] fifo_dataout;
    logic             fifo_rdempty;
    logic [PTR:0]     fifo_rdusedw;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sop;
    logic             out_eop;

    modport master (
        output fifo_rden,
        input  fifo_dataout,
        input  fifo_rdempty,
        input  fifo_rdusedw,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_sop,
        output out_eop
    );

    modport slave (
        input  fifo_rden,
        output fifo_dataout,
        output fifo_rdempty,
        output fifo_rdusedw,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_sop,
        input  out_eop
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains the async FIFO read side in bursts of up to BURST_LEN words, tagged with sop/eop.
// Latency: word leaves 2 cycles after its read request; backpressure: out_ready stalls the 2-entry skid, which throttles fifo_rden.
module fifo_burst_reader #(
    parameter int WIDTH     = 8,
    parameter int PTR       = 4,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 32
) (
    input  logic                rdclk,
    input  logic                reset_,
    fifo_burst_reader_if.master bus,
    output logic [15:0]         burst_cnt,
    output logic                dbg
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = PTR + 1;
    localparam int TO_LAST_I = TIMEOUT - 1;
    localparam logic [RW-1:0] BL      = BURST_LEN[RW-1:0];
    localparam logic [TW-1:0] TO_LAST = TO_LAST_I[TW-1:0];

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    typedef struct packed {
        logic             sop;
        logic             eop;
        logic [WIDTH-1:0] dat;
    } entry_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [RW-1:0] remaining, remaining_nxt;
    logic          first, first_nxt;
    logic [15:0]   burst_cnt_nxt;

    logic          inflight;
    logic          inflight_sop;
    logic          inflight_eop;
    entry_t        skid0, skid1;
    entry_t        in_entry;
    logic [1:0]    occ;
    logic [2:0]    fill;
    logic          pop;
    logic          rden;

    assign pop      = (occ != 2'd0) && bus.out_ready;
    // Entries that will be held after this edge if no new read is issued.
    assign fill     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign in_entry = '{sop: inflight_sop, eop: inflight_eop, dat: bus.fifo_dataout};

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        remaining_nxt = remaining;
        first_nxt     = first;
        burst_cnt_nxt = burst_cnt;
        rden          = 1'b0;
        case (state)
            IDLE: begin
                if (bus.fifo_rdusedw != '0) begin
                    if (bus.fifo_rdusedw >= BL || timer == TO_LAST) begin
                        state_nxt     = BURST;
                        remaining_nxt = (bus.fifo_rdusedw >= BL) ? BL : bus.fifo_rdusedw;
                        first_nxt     = 1'b1;
                        timer_nxt     = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end else begin
                    timer_nxt = '0;
                end
            end
            BURST: begin
                // An empty glitch only pauses the burst; remaining is held until data returns.
                rden = !bus.fifo_rdempty && (remaining != '0) && (fill < 3'd2);
                if (rden) begin
                    remaining_nxt = remaining - RW'(1);
                    first_nxt     = 1'b0;
                    if (remaining == RW'(1)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
                    state_nxt     = IDLE;
                    burst_cnt_nxt = burst_cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rdclk or negedge reset_) begin
        if (!reset_) begin
            state     <= IDLE;
            timer     <= '0;
            remaining <= '0;
            first     <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            remaining <= remaining_nxt;
            first     <= first_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    always_ff @(posedge rdclk or negedge reset_) begin
        if (!reset_) begin
            inflight     <= 1'b0;
            inflight_sop <= 1'b0;
            inflight_eop <= 1'b0;
            skid0        <= '0;
            skid1        <= '0;
            occ          <= 2'd0;
        end else begin
            inflight     <= rden;
            inflight_sop <= rden & first;
            inflight_eop <= rden & (remaining == RW'(1));
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        skid0 <= in_entry;
                    end else begin
                        skid1 <= in_entry;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    skid0 <= skid1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    // Push and pop together: occupancy unchanged, no bubble.
                    if (occ == 2'd2) begin
                        skid0 <= skid1;
                        skid1 <= in_entry;
                    end else begin
                        skid0 <= in_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.fifo_rden = rden;
    assign bus.out_valid = (occ != 2'd0);
    assign bus.out_data  = skid0.dat;
    assign bus.out_sop   = skid0.sop & (occ != 2'd0);
    assign bus.out_eop   = skid0.eop & (occ != 2'd0);
    assign dbg           = 1'b0;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench: a queue-based FIFO feeds the reader; a burst-level model predicts data order and sop/eop/burst count.
module tb_fifo_burst_reader;
    localparam int WIDTH = 8;
    localparam int PTR   = 4;
    localparam int BL    = 8;
    localparam int TO    = 32;
    localparam int DEPTH = 16;

    logic        rdclk = 1'b0;
    logic        reset_ = 1'b0;
    logic [15:0] burst_cnt;
    logic        dbg;

    fifo_burst_reader_if #(.WIDTH(WIDTH), .PTR(PTR)) bus();

    fifo_burst_reader #(.WIDTH(WIDTH), .PTR(PTR), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .rdclk     (rdclk),
        .reset_    (reset_),
        .bus       (bus),
        .burst_cnt (burst_cnt),
        .dbg       (dbg)
    );

    always #5 rdclk = ~rdclk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] exp_q[$];
    int               len_q[$];
    bit               force_empty;
    bit               m_idle;
    int               m_t;
    int               rd_left;
    int               pos;
    int               n_eop;
    int               held;
    bit               rden_s;
    bit               stall_prev;
    logic [WIDTH+1:0] snap;
    int               rd_run, max_run, idle_wait, rd_window;
    bit               seen_rd;
    bit               last_sop, last_eop;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic upd_flags();
        bus.fifo_rdusedw = (PTR+1)'(fq.size());
        bus.fifo_rdempty = (fq.size() == 0) || force_empty;
    endtask

    task automatic wr(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            fq.push_back(WIDTH'(base + i));
            exp_q.push_back(WIDTH'(base + i));
        end
    endtask

    task automatic model_reset();
        fq.delete(); exp_q.delete(); len_q.delete();
        m_idle = 1; m_t = 0; rd_left = 0; pos = 0; n_eop = 0; held = 0;
        rden_s = 0; stall_prev = 0; force_empty = 0;
    endtask

    // One clock: sample and score at the falling edge, then apply FIFO side effects just after the rising edge.
    task automatic tick();
        bit xfer;
        int u, len;
        logic [WIDTH-1:0] e;
        upd_flags();
        @(negedge rdclk);
        xfer = bus.out_valid && bus.out_ready;
        check_eq("burst_cnt", burst_cnt, 32'(n_eop & 16'hffff));
        check_eq("rden_while_empty", 32'(bus.fifo_rden && bus.fifo_rdempty), 0);
        if (stall_prev) begin
            check_eq("hold_valid", bus.out_valid, 1);
            check_eq("hold_out", {bus.out_sop, bus.out_eop, bus.out_data}, snap);
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        snap = {bus.out_sop, bus.out_eop, bus.out_data};
        if (bus.fifo_rden) begin
            check_eq("rd_budget", 32'(rd_left > 0), 1);
            check_eq("skid_room", 32'(held + 1 - int'(xfer) <= 2), 1);
            rd_left--;
            rd_run++;
            if (rd_run > max_run) max_run = rd_run;
            seen_rd = 1;
        end else begin
            rd_run = 0;
            if (!seen_rd) idle_wait++;
        end
        held = held + int'(bus.fifo_rden) - int'(xfer);
        if (m_idle) begin
            u = fq.size();
            if (u >= BL || (u != 0 && m_t == TO - 1)) begin
                len = (u >= BL) ? BL : u;
                len_q.push_back(len);
                rd_left = len;
                m_idle = 0;
                m_t = 0;
            end else begin
                m_t = (u != 0) ? m_t + 1 : 0;
            end
        end
        if (xfer) begin
            check_eq("xfer_expected", 32'(exp_q.size() != 0 && len_q.size() != 0), 1);
            if (exp_q.size() != 0 && len_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("data", bus.out_data, e);
                check_eq("sop", bus.out_sop, 32'(pos == 0));
                check_eq("eop", bus.out_eop, 32'(pos == len_q[0] - 1));
                last_sop = bus.out_sop;
                last_eop = bus.out_eop;
                pos++;
                if (pos == len_q[0]) begin
                    void'(len_q.pop_front());
                    pos = 0;
                    n_eop++;
                    m_idle = 1;
                    m_t = 0;
                end
            end
        end
        rden_s = bus.fifo_rden;
        @(posedge rdclk);
        #1;
        if (rden_s && fq.size() != 0) bus.fifo_dataout = fq.pop_front();
    endtask

    task automatic run_until_eop(input string tag, input int target, input int limit);
        for (int i = 0; i < limit && n_eop < target; i++) tick();
        check_eq(tag, n_eop, target);
    endtask

    task automatic clr_stats();
        rd_run = 0; max_run = 0; idle_wait = 0; seen_rd = 0;
    endtask

    initial begin
        bus.fifo_dataout = '0;
        bus.out_ready    = 1'b0;
        model_reset();
        upd_flags();
        #1;
        check_eq("rst_valid", bus.out_valid, 0);
        check_eq("rst_rden", bus.fifo_rden, 0);
        check_eq("rst_sop_eop", {bus.out_sop, bus.out_eop}, 0);
        check_eq("rst_data", bus.out_data, 0);
        check_eq("rst_burst_cnt", burst_cnt, 0);
        check_eq("dbg", dbg, 0);
        repeat (3) @(posedge rdclk);
        #1 reset_ = 1'b1;

        // Full burst, continuous ready.
        bus.out_ready = 1'b1;
        clr_stats();
        wr(8, 'h10);
        run_until_eop("t1_done", 1, 100);
        check_eq("t1_rden_run", max_run, 8);
        check_eq("t1_burst_cnt", burst_cnt, 1);

        // Partial burst flushed only after the idle timeout.
        clr_stats();
        wr(3, 'h20);
        run_until_eop("t2_done", 2, 200);
        check_eq("t2_wait", idle_wait, TO);

        // Two full bursts under alternating ready.
        clr_stats();
        wr(16, 'h30);
        for (int i = 0; i < 300 && n_eop < 4; i++) begin
            bus.out_ready = ~bus.out_ready;
            tick();
        end
        check_eq("t3_done", n_eop, 4);
        check_eq("t3_fifo_empty", fq.size(), 0);
        bus.out_ready = 1'b1;

        // Single word burst.
        wr(1, 'h55);
        run_until_eop("t4_done", 5, 200);
        check_eq("t4_sop_eop", {last_sop, last_eop}, 2'b11);

        // Empty glitch mid-burst.
        clr_stats();
        wr(8, 'h40);
        for (int i = 0; i < 100 && !seen_rd; i++) tick();
        tick(); tick();
        force_empty = 1;
        rd_window = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            rd_window += int'(rden_s);
        end
        force_empty = 0;
        check_eq("t5_rden_window", rd_window, 0);
        run_until_eop("t5_done", 6, 100);
        check_eq("t5_rd_left", rd_left, 0);

        // Reset while a word is presented.
        bus.out_ready = 1'b0;
        wr(8, 'h70);
        for (int i = 0; i < 100 && !bus.out_valid; i++) tick();
        check_eq("t6_valid_before", bus.out_valid, 1);
        reset_ = 1'b0;
        #1;
        check_eq("t6_rst_valid", bus.out_valid, 0);
        check_eq("t6_rst_rden", bus.fifo_rden, 0);
        check_eq("t6_rst_cnt", burst_cnt, 0);
        model_reset();
        upd_flags();
        @(posedge rdclk);
        #1 reset_ = 1'b1;
        bus.out_ready = 1'b1;
        wr(8, 'h60);
        run_until_eop("t6_done", 1, 100);
        check_eq("t6_burst_cnt", burst_cnt, 1);

        // Random writes, ready and empty glitches.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 9) < 3 && fq.size() < DEPTH) begin
                fq.push_back(WIDTH'($urandom));
                exp_q.push_back(fq[fq.size() - 1]);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            force_empty   = ($urandom_range(0, 15) == 0);
            tick();
        end
        force_empty   = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 500 && (exp_q.size() != 0 || !m_idle); i++) tick();
        check_eq("rand_drained", exp_q.size(), 0);
        check_eq("rand_idle", m_idle, 1);
        tick();
        check_eq("rand_burst_cnt", burst_cnt, 32'(n_eop & 16'hffff));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
